vga_timing_ctrl: RTL and testbench
==================================

// Module: vga_timing_ctrl
// PURPOSE
//  Raster timing generator for the 640x480@60 VGA path. Divides the system clock
//  into a pixel strobe, runs horizontal/vertical counters, and drives x/y to the
//  pixel-paint stage directly downstream, which turns x/y into RGB. Also drives
//  hsync/vsync/blank_n/sync_n/vga_clk to the board DAC and connector.
// PARAMETERS
//  CLK_DIV   2    system clocks per pixel; even, >=2 (elaboration error otherwise)
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   hsync pulse width, pixels
//  H_BP      48   horizontal back porch, pixels (H_TOTAL = 800)
//  V_ACTIVE  480  visible lines
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vsync pulse width, lines
//  V_BP      33   vertical back porch, lines (V_TOTAL = 525)
//  SYNC_DLY  2    pixel-strobe delay on sync/blank (used only with macro)
// PORTS
//  clk          in   1   system clock (50 MHz)
//  rst_n        in   1   asynchronous active-low reset
//  pix_tick     out  1   one-clk pixel strobe; decoded from divider register
//  vga_clk      out  1   DAC pixel clock, 50% duty, period CLK_DIV clks
//  x            out  10  horizontal count 0..H_TOTAL-1 (raw, includes blanking)
//  y            out  10  vertical count 0..V_TOTAL-1 (raw)
//  hsync        out  1   horizontal sync, active low
//  vsync        out  1   vertical sync, active low
//  blank_n      out  1   1 = (x,y) inside the visible area
//  sync_n       out  1   DAC composite sync; tied 0
//  line_start   out  1   one-clk pulse when x wraps to 0
//  frame_start  out  1   one-clk pulse when (x,y) wraps to (0,0)
// BEHAVIOUR
//  - Reset (async, immediate): div_cnt=0, x=0, y=0, vga_clk=0, pix_tick=0,
//    hsync=1, vsync=1, blank_n=1, line_start=0, frame_start=0.
//  - Divider: div_cnt counts 0..CLK_DIV-1, wraps. pix_tick = (div_cnt==CLK_DIV-1).
//    vga_clk = (div_cnt >= CLK_DIV/2); its rising edge falls mid-pixel.
//  - Counters advance only on a clk edge where pix_tick=1:
//    x==H_TOTAL-1 -> x=0 and y advances; y==V_TOTAL-1 with x wrap -> y=0.
//    No other edge changes x/y.
//  - hsync, vsync, and blank_n are registered. Each is loaded on the same edge as
//    x/y from the next-count decode, so they are cycle-aligned with x/y (0 latency):
//    hsync=0 iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC   (656..751)
//    vsync=0 iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC   (490..491)
//    blank_n=1 iff x<H_ACTIVE && y<V_ACTIVE
//  - line_start and frame_start are registered. Each is high for exactly the one clk
//    after the wrapping edge, and never asserted coming out of reset.
//    Simultaneous x and y wrap: both pulses high in the same clk.
//  - Widths: 10-bit counters, compare against constants; no overflow past TOTAL-1.
//  - Reset mid-frame: all state and outputs return to reset values at once.
//    The raster restarts at (0,0) on release. No frame_start for the truncated frame.
// CONFIGURATION
//  VGA_SYNC_DELAY_EN defined: hsync, vsync, and blank_n pass through a
//    SYNC_DLY-deep shift register that advances only on pix_tick.
//    They lag x/y by SYNC_DLY pixels, matching a registered RGB pipeline downstream.
//    Reset value of every delay stage: hsync=1, vsync=1, blank_n=0.
//  Not defined: no delay stages; zero-latency alignment as above.
//    x, y, line_start, and frame_start are unaffected in both cases.
// TESTING
//  1. Release reset, CLK_DIV=2 -> pix_tick every 2nd clk; hsync first falls at
//     x=656 (edge 1312 after release), low for 192 clks, period 1600 clks.
//  2. Run 2 frames -> vsync low exactly while y in 490..491 (3200 clks);
//     frame period 840000 clks; frame_start spacing 840000 clks.
//  3. Count pix_tick cycles with blank_n=1 per frame -> 307200; blank_n=0 whenever
//     x>=640 or y>=480.
//  4. Reach (799,524), then next pix_tick edge -> x=0, y=0; line_start and frame_start
//     both high one clk; at (799,10) -> only line_start.
//  5. Drop rst_n at (400,300) between clk edges -> outputs at reset values before the
//     next clk edge; after release the first hsync fall is again at edge 1312.
//  6. With VGA_SYNC_DELAY_EN, SYNC_DLY=2 -> hsync falls while x==658 and blank_n
//     falls while x==642. Without the macro -> hsync falls at x==656, blank_n at 640.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// Raster timing generator for the 640x480@60 VGA path: pixel divider, h/v counters, sync/blank decode.
// Optional macro VGA_SYNC_DELAY_EN delays hsync/vsync/blank_n by SYNC_DLY pixels to track a registered RGB stage.
module vga_timing_ctrl #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_DLY = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       pix_tick,
   output logic       vga_clk,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       hsync,
   output logic       vsync,
   output logic       blank_n,
   output logic       sync_n,
   output logic       line_start,
   output logic       frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]       H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0]       V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0]       HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]       HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]       VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]       VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   generate
      if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
         $error("vga_timing_ctrl: CLK_DIV must be even and >= 2");
      end
      if (SYNC_DLY < 1) begin : g_bad_sync_dly
         $error("vga_timing_ctrl: SYNC_DLY must be >= 1");
      end
      if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
         $error("vga_timing_ctrl: raster totals must fit the 10-bit counters");
      end
   endgenerate

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_next;
   logic [9:0]       x_next;
   logic [9:0]       y_next;
   logic             line_wrap;
   logic             frame_wrap;
   logic             hs_now;
   logic             vs_now;
   logic             bl_now;
   logic             hs_next;
   logic             vs_next;
   logic             bl_next;

   assign pix_tick = (div_cnt == DIV_LAST);
   assign sync_n   = 1'b0;

   // Sync/blank are decoded from the next count so the registered versions land on the same edge as x/y.
   always_comb begin
      div_next   = pix_tick ? '0 : div_cnt + 1'b1;
      line_wrap  = pix_tick && (x == H_LAST);
      frame_wrap = line_wrap && (y == V_LAST);
      x_next     = x;
      y_next     = y;
      if (pix_tick) begin
         if (line_wrap) begin
            x_next = '0;
            y_next = frame_wrap ? '0 : y + 10'd1;
         end else begin
            x_next = x + 10'd1;
         end
      end
      hs_next = !((x_next >= HS_START) && (x_next < HS_END));
      vs_next = !((y_next >= VS_START) && (y_next < VS_END));
      bl_next = (x_next < H_VIS) && (y_next < V_VIS);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt     <= '0;
         vga_clk     <= 1'b0;
         x           <= '0;
         y           <= '0;
         hs_now      <= 1'b1;
         vs_now      <= 1'b1;
         bl_now      <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         div_cnt     <= div_next;
         vga_clk     <= (div_next >= DIV_HALF);
         x           <= x_next;
         y           <= y_next;
         hs_now      <= hs_next;
         vs_now      <= vs_next;
         bl_now      <= bl_next;
         line_start  <= line_wrap;
         frame_start <= frame_wrap;
      end
   end

`ifdef VGA_SYNC_DELAY_EN
   logic [SYNC_DLY-1:0] hs_pipe;
   logic [SYNC_DLY-1:0] vs_pipe;
   logic [SYNC_DLY-1:0] bl_pipe;

   // Stages step once per pixel, so the lag is SYNC_DLY pixels regardless of CLK_DIV.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_pipe <= '1;
         vs_pipe <= '1;
         bl_pipe <= '0;
      end else if (pix_tick) begin
         hs_pipe[0] <= hs_now;
         vs_pipe[0] <= vs_now;
         bl_pipe[0] <= bl_now;
         for (int i = 1; i < SYNC_DLY; i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
            bl_pipe[i] <= bl_pipe[i-1];
         end
      end
   end

   assign hsync   = hs_pipe[SYNC_DLY-1];
   assign vsync   = vs_pipe[SYNC_DLY-1];
   assign blank_n = bl_pipe[SYNC_DLY-1];
`else
   assign hsync   = hs_now;
   assign vsync   = vs_now;
   assign blank_n = bl_now;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl: full horizontal timing, shortened vertical raster.
// Expected outputs come from an arithmetic model indexed by clock edges since reset release.
module tb_vga_timing_ctrl;

   localparam int H_TOTAL    = 800;
   localparam int V_ACTIVE   = 6;
   localparam int V_FP       = 2;
   localparam int V_SYNC     = 2;
   localparam int V_BP       = 2;
   localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int FRAME_CLKS = 2 * H_TOTAL * V_TOTAL;
   localparam int MAX_FAILS  = 20;
`ifdef VGA_SYNC_DELAY_EN
   localparam int LAG = 2;
`else
   localparam int LAG = 0;
`endif

   typedef struct packed {
      logic       pix_tick;
      logic       vga_clk;
      logic [9:0] x;
      logic [9:0] y;
      logic       hsync;
      logic       vsync;
      logic       blank_n;
      logic       sync_n;
      logic       line_start;
      logic       frame_start;
   } obs_t;

   logic       clk;
   logic       rst_n;
   logic       pix_tick;
   logic       vga_clk;
   logic [9:0] x;
   logic [9:0] y;
   logic       hsync;
   logic       vsync;
   logic       blank_n;
   logic       sync_n;
   logic       line_start;
   logic       frame_start;

   int   assert_count = 0;
   int   fail_count   = 0;
   int   n;
   obs_t sb_q[$];

   int   hs_falls, hs_first_fall, hs_fall_x, hs_period, hs_run, hs_low_len;
   int   bl_fall_x, fs_count, last_fs, fs_spacing, fs_bad;
   int   blank_acc, blank_pix, vs_acc, vs_low, ls_count;
   logic prev_hs, prev_bl;

   vga_timing_ctrl #(
      .CLK_DIV  (2),
      .H_ACTIVE (640),
      .H_FP     (16),
      .H_SYNC   (96),
      .H_BP     (48),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .SYNC_DLY (2)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_tick    (pix_tick),
      .vga_clk     (vga_clk),
      .x           (x),
      .y           (y),
      .hsync       (hsync),
      .vsync       (vsync),
      .blank_n     (blank_n),
      .sync_n      (sync_n),
      .line_start  (line_start),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs after the n-th clock edge following reset release (n=0 is the reset state).
   function automatic obs_t model_at(input int edge_n);
      obs_t o;
      int   p, xm, ym, q, xq, yq;
      p  = edge_n / 2;
      xm = p % H_TOTAL;
      ym = (p / H_TOTAL) % V_TOTAL;
      o.pix_tick    = (edge_n % 2) == 1;
      o.vga_clk     = (edge_n % 2) == 1;
      o.x           = 10'(xm);
      o.y           = 10'(ym);
      o.sync_n      = 1'b0;
      o.line_start  = (edge_n > 0) && (edge_n % 2 == 0) && (xm == 0);
      o.frame_start = o.line_start && (ym == 0);
      q = p - LAG;
      if (q < 0) begin
         o.hsync   = 1'b1;
         o.vsync   = 1'b1;
         o.blank_n = 1'b0;
      end else begin
         xq = q % H_TOTAL;
         yq = (q / H_TOTAL) % V_TOTAL;
         o.hsync   = !(xq >= 656 && xq < 752);
         o.vsync   = !(yq >= V_ACTIVE + V_FP && yq < V_ACTIVE + V_FP + V_SYNC);
         o.blank_n = (xq < 640) && (yq < V_ACTIVE);
      end
      return o;
   endfunction

   function automatic obs_t sample_outputs();
      obs_t o;
      o.pix_tick    = pix_tick;
      o.vga_clk     = vga_clk;
      o.x           = x;
      o.y           = y;
      o.hsync       = hsync;
      o.vsync       = vsync;
      o.blank_n     = blank_n;
      o.sync_n      = sync_n;
      o.line_start  = line_start;
      o.frame_start = frame_start;
      return o;
   endfunction

   task automatic finishTest();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
      assert_count++;
      if (got !== want) begin
         fail_count++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, want);
         if (fail_count >= MAX_FAILS) finishTest();
      end
   endtask

   task automatic clearMeasures();
      obs_t r;
      r = model_at(0);
      hs_falls = 0; hs_first_fall = -1; hs_fall_x = -1; hs_period = -1;
      hs_run = 0; hs_low_len = -1; bl_fall_x = -1;
      fs_count = 0; last_fs = 0; fs_spacing = -1; fs_bad = 0;
      blank_acc = 0; blank_pix = -1; vs_acc = 0; vs_low = -1; ls_count = 0;
      prev_hs = r.hsync;
      prev_bl = r.blank_n;
   endtask

   task automatic trackEvents(input obs_t got);
      if (prev_hs && !got.hsync) begin
         if (hs_falls == 0) begin
            hs_first_fall = n;
            hs_fall_x     = int'(got.x);
         end else if (hs_falls == 1) begin
            hs_period = n - hs_first_fall;
         end
         hs_falls++;
         hs_run = 0;
      end
      if (!got.hsync) hs_run++;
      if (!prev_hs && got.hsync && hs_low_len < 0) hs_low_len = hs_run;
      if (prev_bl && !got.blank_n && bl_fall_x < 0) bl_fall_x = int'(got.x);
      if (got.frame_start) begin
         if (fs_count == 1) begin
            fs_spacing = n - last_fs;
            blank_pix  = blank_acc;
            vs_low     = vs_acc;
         end
         if (got.x != 10'd0 || got.y != 10'd0 || !got.line_start) fs_bad++;
         blank_acc = 0;
         vs_acc    = 0;
         last_fs   = n;
         fs_count++;
      end
      if (got.pix_tick && got.blank_n) blank_acc++;
      if (!got.vsync) vs_acc++;
      if (got.line_start) ls_count++;
      prev_hs = got.hsync;
      prev_bl = got.blank_n;
   endtask

   // Each edge pushes the model's prediction; the opposite edge pops it against the DUT.
   task automatic applyStimulus(input int cycles);
      obs_t want, got;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         n++;
         sb_q.push_back(model_at(n));
         @(negedge clk);
         want = sb_q.pop_front();
         got  = sample_outputs();
         checkOutput("raster", 64'(got), 64'(want));
         trackEvents(got);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      n     = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_state", 64'(sample_outputs()), 64'(model_at(0)));

      rst_n = 1'b1;
      n     = 0;
      clearMeasures();
      applyStimulus(2 * FRAME_CLKS + 200);
      checkOutput("hs_first_fall_edge", 64'(hs_first_fall), 64'(1312 + 2 * LAG));
      checkOutput("hs_fall_x", 64'(hs_fall_x), 64'(656 + LAG));
      checkOutput("hs_low_clks", 64'(hs_low_len), 64'(192));
      checkOutput("hs_period", 64'(hs_period), 64'(1600));
      checkOutput("blank_fall_x", 64'(bl_fall_x), 64'(640 + LAG));
      checkOutput("frame_count", 64'(fs_count), 64'(2));
      checkOutput("frame_spacing", 64'(fs_spacing), 64'(FRAME_CLKS));
      checkOutput("frame_at_origin", 64'(fs_bad), 64'(0));
      checkOutput("visible_pixels", 64'(blank_pix), 64'(640 * V_ACTIVE));
      checkOutput("vsync_low_clks", 64'(vs_low), 64'(2 * 1600));
      checkOutput("line_count", 64'(ls_count), 64'(2 * V_TOTAL));

      applyStimulus(2 * (2 * H_TOTAL * V_TOTAL + 5 * H_TOTAL + 400) - n);
      checkOutput("pre_reset_x", 64'(x), 64'(400));
      checkOutput("pre_reset_y", 64'(y), 64'(5));
      #2 rst_n = 1'b0;
      #1 checkOutput("async_reset", 64'(sample_outputs()), 64'(model_at(0)));
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("held_reset", 64'(sample_outputs()), 64'(model_at(0)));

      rst_n = 1'b1;
      n     = 0;
      clearMeasures();
      applyStimulus(1700);
      checkOutput("restart_hs_fall_edge", 64'(hs_first_fall), 64'(1312 + 2 * LAG));
      checkOutput("restart_no_frame", 64'(fs_count), 64'(0));
      checkOutput("restart_line_count", 64'(ls_count), 64'(1));

      finishTest();
   end

endmodule
